// File: rtl/key_autorepeat.sv
// Four-channel press/hold auto-repeat: debounced button levels in, single-cycle
// step pulses out, with opposing presses on one axis locked out.
module key_autorepeat #(
   parameter int HOLD_CYC   = 25000000,
   parameter int REPEAT_CYC = 5000000,
   parameter int CNT_W      = 25
) (
   input  logic       sysclk,
   input  logic       Reset_Sw,
   input  logic       Up_deb,
   input  logic       Down_deb,
   input  logic       Left_deb,
   input  logic       Right_deb,
   output logic       Step_Up,
   output logic       Step_Down,
   output logic       Step_Left,
   output logic       Step_Right,
   output logic [3:0] Held
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_BLOCKED
   } ch_state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   ch_state_t        state_q [4];
   ch_state_t        state_d [4];
   logic [CNT_W-1:0] cnt_q   [4];
   logic [CNT_W-1:0] cnt_d   [4];

   logic [3:0] btn;
   logic [3:0] pair_hit;
   logic [3:0] pair_clear;
   logic [3:0] pulse_d;
   logic [3:0] held_d;
   logic [3:0] step_p1;
   logic [3:0] held_p1;

   // Channel order everywhere: {Right, Left, Down, Up}; partner of i is i^1.
   assign btn = {Right_deb, Left_deb, Down_deb, Up_deb};

   always_comb begin
      pair_hit   = '0;
      pair_clear = '0;
      for (int i = 0; i < 4; i++) begin
         pair_hit[i]   = btn[i] & btn[i ^ 1];
         pair_clear[i] = ~btn[i] & ~btn[i ^ 1];
      end
   end

   always_comb begin
      pulse_d = '0;
      held_d  = '0;
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (pair_hit[i]) begin
            state_d[i] = ST_BLOCKED;
            cnt_d[i]   = CNT_ZERO;
         end else begin
            unique case (state_q[i])
               ST_IDLE: begin
                  if (btn[i]) begin
                     state_d[i] = ST_DELAY;
                     cnt_d[i]   = CNT_ZERO;
                     pulse_d[i] = 1'b1;
                  end
               end
               ST_DELAY: begin
                  if (!btn[i]) begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = CNT_ZERO;
                  end else if (cnt_q[i] >= HOLD_LAST) begin
                     state_d[i] = ST_REPEAT;
                     cnt_d[i]   = CNT_ZERO;
                     pulse_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
               ST_REPEAT: begin
                  if (!btn[i]) begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = CNT_ZERO;
                  end else if (cnt_q[i] >= REPEAT_LAST) begin
                     cnt_d[i]   = CNT_ZERO;
                     pulse_d[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_ONE;
                  end
               end
               ST_BLOCKED: begin
                  // Only a full release of both buttons of the axis unlocks it.
                  cnt_d[i] = CNT_ZERO;
                  if (pair_clear[i]) begin
                     state_d[i] = ST_IDLE;
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = CNT_ZERO;
               end
            endcase
         end
         held_d[i] = (state_d[i] == ST_REPEAT);
      end
   end

   // Stage boundary: state, counters and registered outputs.
   always_ff @(posedge sysclk or negedge Reset_Sw) begin
      if (!Reset_Sw) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= CNT_ZERO;
         end
         step_p1 <= '0;
         held_p1 <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         step_p1 <= pulse_d;
         held_p1 <= held_d;
      end
   end

   assign Step_Up    = step_p1[0];
   assign Step_Down  = step_p1[1];
   assign Step_Left  = step_p1[2];
   assign Step_Right = step_p1[3];
   assign Held       = held_p1;

endmodule

// File: tb/tb_key_autorepeat.sv
// Scoreboard bench for key_autorepeat: directed scenarios plus random holds,
// checked against an edge-counting reference model.
module tb_key_autorepeat;

   localparam int H = 8;
   localparam int R = 4;

   logic       sysclk;
   logic       Reset_Sw;
   logic       Up_deb, Down_deb, Left_deb, Right_deb;
   logic       Step_Up, Step_Down, Step_Left, Step_Right;
   logic [3:0] Held;

   int tests_run;
   int tests_failed;
   int cycle_no;

   logic [7:0] exp_q [$];

   key_autorepeat #(
      .HOLD_CYC  (H),
      .REPEAT_CYC(R),
      .CNT_W     (4)
   ) dut (
      .sysclk    (sysclk),
      .Reset_Sw  (Reset_Sw),
      .Up_deb    (Up_deb),
      .Down_deb  (Down_deb),
      .Left_deb  (Left_deb),
      .Right_deb (Right_deb),
      .Step_Up   (Step_Up),
      .Step_Down (Step_Down),
      .Step_Left (Step_Left),
      .Step_Right(Step_Right),
      .Held      (Held)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   // Reference model: per channel, how many edges the current press has lasted.
   int         hold_n [4];
   bit         active [4];
   bit         blocked[2];
   logic [3:0] m_btn, m_step, m_held;

   always @(posedge sysclk) begin
      m_btn  = {Right_deb, Left_deb, Down_deb, Up_deb};
      m_step = '0;
      m_held = '0;
      if (!Reset_Sw) begin
         for (int c = 0; c < 4; c++) begin
            hold_n[c] = 0;
            active[c] = 0;
         end
         blocked[0] = 0;
         blocked[1] = 0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (m_btn[2*p] && m_btn[2*p+1]) begin
               blocked[p]   = 1;
               active[2*p]   = 0;
               active[2*p+1] = 0;
            end else if (blocked[p]) begin
               if (!m_btn[2*p] && !m_btn[2*p+1]) blocked[p] = 0;
            end else begin
               for (int c = 2*p; c <= 2*p+1; c++) begin
                  if (m_btn[c]) begin
                     if (active[c]) hold_n[c] = hold_n[c] + 1;
                     else begin
                        active[c] = 1;
                        hold_n[c] = 0;
                     end
                     if (hold_n[c] == 0 || (hold_n[c] >= H && (hold_n[c] - H) % R == 0))
                        m_step[c] = 1'b1;
                  end else begin
                     active[c] = 0;
                  end
               end
            end
         end
         for (int c = 0; c < 4; c++)
            m_held[c] = active[c] && (hold_n[c] >= H);
      end
      exp_q.push_back({m_held, m_step});
   end

   // Monitor: one output word per cycle, compared away from the clock edge.
   always @(posedge sysclk) begin
      logic [7:0] act, expv;
      #1;
      cycle_no++;
      act = {Held, Step_Right, Step_Left, Step_Down, Step_Up};
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL scoreboard_empty cycle %0d actual %b", cycle_no, act);
      end else begin
         expv = exp_q.pop_front();
         if (act !== expv) begin
            tests_failed++;
            $display("FAIL cycle_out cycle %0d actual held/steps %b required %b",
                     cycle_no, act, expv);
         end
      end
   end

   task automatic hold(input logic [3:0] b, input int n);
      @(negedge sysclk);
      {Right_deb, Left_deb, Down_deb, Up_deb} = b;
      repeat (n) @(posedge sysclk);
   endtask

   // Called right after a rising edge: reset lands mid-cycle.
   task automatic async_reset(input string name);
      logic [7:0] act;
      #3;
      Reset_Sw = 1'b0;
      #1;
      act = {Held, Step_Right, Step_Left, Step_Down, Step_Up};
      tests_run++;
      if (act !== 8'h00) begin
         tests_failed++;
         $display("FAIL %s actual held/steps %b required 00000000", name, act);
      end
      @(posedge sysclk);
      @(negedge sysclk);
      Reset_Sw = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] rb;
      tests_run    = 0;
      tests_failed = 0;
      cycle_no     = 0;
      Reset_Sw     = 1'b0;
      {Right_deb, Left_deb, Down_deb, Up_deb} = 4'b0000;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      Reset_Sw = 1'b1;
      hold(4'b0000, 2);

      // Short tap on Up
      hold(4'b0001, 3);
      hold(4'b0000, 5);
      // Sustained Right
      hold(4'b1000, 20);
      hold(4'b0000, 3);
      // Down released on a due edge
      hold(4'b0010, 12);
      hold(4'b0000, 4);
      // Left held, Right joins, Right leaves, release, re-press Left
      hold(4'b0100, 5);
      hold(4'b1100, 5);
      hold(4'b0100, 6);
      hold(4'b0000, 2);
      hold(4'b0100, 3);
      hold(4'b0000, 3);
      // Up+Down rise together while Left runs normally
      hold(4'b0111, 14);
      hold(4'b0000, 3);
      // Async reset mid-repeat with Up still held
      hold(4'b0001, 14);
      async_reset("reset_mid_repeat");
      hold(4'b0001, 12);
      hold(4'b0000, 3);

      // Random long holds with occasional mid-cycle resets
      rb = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 11) == 0) rb[c] = ~rb[c];
         hold(rb, 1);
         if ($urandom_range(0, 399) == 0) async_reset("reset_random");
      end
      hold(4'b0000, 3);

      @(negedge sysclk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/key_autorepeat.md
Name: key_autorepeat

Overview:
Four-channel press/hold auto-repeat stage between the quad debouncer and the position stepper. It converts debounced button levels into single-cycle step pulses. A press gives one pulse immediately; a sustained hold gives further pulses at a fixed rate after an initial delay. Simultaneous opposing presses on one axis (Up+Down or Left+Right) are blocked, so the stepper never receives contradictory steps.

Parameters:
HOLD_CYC, 25000000, cycles from the first pulse to the first repeat pulse (0.5 s at 50 MHz); legal range >= 2
REPEAT_CYC, 5000000, cycles between successive repeat pulses; legal range >= 2
CNT_W, 25, counter width; must hold max(HOLD_CYC, REPEAT_CYC)

Ports:
sysclk  in  1  system clock, all state on rising edge
Reset_Sw  in  1  asynchronous active-low reset
Up_deb  in  1  debounced Up level, 1 = pressed
Down_deb  in  1  debounced Down level
Left_deb  in  1  debounced Left level
Right_deb  in  1  debounced Right level
Step_Up  out  1  registered single-cycle step pulse
Step_Down  out  1  registered single-cycle step pulse
Step_Left  out  1  registered single-cycle step pulse
Step_Right  out  1  registered single-cycle step pulse
Held  out  4  {Right,Left,Down,Up}; 1 while the channel is in REPEAT

Behaviour:
- Reset (Reset_Sw = 0, asynchronous, any time including mid-hold):
  - all channels go to IDLE; all counters = 0.
  - All Step_* = 0 and Held = 0 immediately.
  - After reset release, a button already held is treated as a new press at the first sampling edge.
- Each channel has an independent FSM (IDLE, DELAY, REPEAT, BLOCKED) and a CNT_W-bit counter. All four channels are identical; the only cross-channel coupling is the pair conflict rule.
- Edge numbering: edge 0 is the first rising edge at which a channel in IDLE samples its input = 1.
- Pulse timing: Step asserts high for exactly one cycle following these edges, provided the input is sampled 1 at every edge up to and including the pulse edge:
  - edge 0;
  - edge HOLD_CYC;
  - then edges HOLD_CYC + k*REPEAT_CYC, for k >= 1.
- Transitions:
  - IDLE -> DELAY at edge 0; the counter is cleared.
  - DELAY -> REPEAT at edge HOLD_CYC; the counter is cleared.
  - REPEAT stays in REPEAT; the counter wraps every REPEAT_CYC edges.
- Release: input sampled 0 at any edge while in DELAY or REPEAT:
  - the channel goes to IDLE at that edge and the counter is cleared;
  - no pulse is issued at that edge, even if one was due there.
- Re-press after release is a new edge 0, with an immediate pulse. There is no minimum gap requirement, since the input is already debounced.
- Pair conflict: pairs are (Up, Down) and (Left, Right).
  - Any edge sampling both inputs of a pair = 1 sends both channels of that pair to BLOCKED, whatever their current state. Their counters are cleared and no pulse is issued at that edge.
  - This includes both inputs rising at the same edge.
  - BLOCKED -> IDLE only at an edge sampling both inputs = 0.
  - While BLOCKED, releasing one button and holding the other produces no pulses.
- Held[i] = 1 exactly while channel i is in REPEAT; it is registered and changes on the same edge as the state.
- Independence: channels on different axes run fully concurrently. Up+Left held together each give their own pulse trains, with Step_Up and Step_Left both high in the same cycle when aligned.
- Counters saturate-safe: no counter value ever exceeds max(HOLD_CYC, REPEAT_CYC) - 1; the counter is cleared on every state change.

Test Plan:
Use HOLD_CYC = 8, REPEAT_CYC = 4 throughout.
- Short tap: Up_deb = 1 for 3 edges (0..2), then 0 -> Step_Up high only after edge 0; Held = 0 throughout; FSM IDLE after edge 3.
- Sustained hold: Right_deb = 1 for 20 edges -> Step_Right pulses after edges 0, 8, 12, 16; Held[3] rises at edge 8; each pulse is exactly 1 cycle wide.
- Release on a due edge: Down_deb held through edge 11 and sampled 0 at edge 12 -> pulses after edges 0 and 8 only; no pulse at 12; Held[1] falls at edge 12.
- Conflict: Left pressed at edge 0 and held; Right pressed at edge 5 -> Step_Left pulse at edge 0 only; nothing at edge 8. Release Right at edge 10 while Left stays held -> still no pulses. Release both, then press Left -> fresh pulse at the new edge 0.
- Simultaneous same-axis rise: Up_deb and Down_deb both rise at the same edge -> no Step_Up or Step_Down ever; concurrently held Left_deb pulses normally at 0, 8, 12.
- Async reset mid-REPEAT: Up held, Reset_Sw driven low between edges 13 and 14 -> Held and all Step_* = 0 at once, without waiting for a clock edge. Deassert reset with Up still held -> new pulse at the first edge, then one at +8.
